bcd_counter_n: RTL and testbench



---
 rtl/bcd_counter_n.sv | 130 +++++++++++++
 tb/tb_bcd_counter_n.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: DIGITS-digit cascaded BCD counter with count enable, parallel load (per-digit
// clamp to 9), wrap or saturate at the range limits, combinational terminal count and a
// registered one-cycle wrap pulse.
// Optional feature macro: BCD_DOWN_EN enables down-counting through `up`; when undefined the
// counter is up-only and `up` is ignored.
module bcd_counter_n #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                count,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  output logic [4*DIGITS-1:0] Q,
  output logic                tc,
  output logic                wrap
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] q_d, q_q;
  logic         wrap_d, wrap_q;

  logic         dir_up;
  logic         at_limit;
  logic         all_nines;
  logic [W-1:0] up_val;
  logic [3:0]   up_dig;
  logic         carry;
  logic [W-1:0] load_clamped;
  logic [3:0]   ld_dig;

`ifdef BCD_DOWN_EN
  logic [W-1:0] down_val;
  logic [3:0]   dn_dig;
  logic         borrow;
  logic         all_zeros;

  assign dir_up   = up;
  assign at_limit = dir_up ? all_nines : all_zeros;
`else
  // Port kept for interface compatibility; up-only build ignores it.
  logic unused_up;

  assign unused_up = up;
  assign dir_up    = 1'b1;
  assign at_limit  = all_nines;
`endif

  // Increment with ripple carry; all-nines rolls naturally to all-zeros.
  always_comb begin
    up_val    = q_q;
    all_nines = 1'b1;
    carry     = 1'b1;
    up_dig    = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      up_dig = q_q[4*k +: 4];
      if (up_dig != 4'd9) all_nines = 1'b0;
      if (carry) begin
        up_val[4*k +: 4] = (up_dig == 4'd9) ? 4'd0 : up_dig + 4'd1;
        carry            = (up_dig == 4'd9);
      end
    end
  end

`ifdef BCD_DOWN_EN
  // Decrement with ripple borrow; all-zeros rolls naturally to all-nines.
  always_comb begin
    down_val  = q_q;
    all_zeros = 1'b1;
    borrow    = 1'b1;
    dn_dig    = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      dn_dig = q_q[4*k +: 4];
      if (dn_dig != 4'd0) all_zeros = 1'b0;
      if (borrow) begin
        down_val[4*k +: 4] = (dn_dig == 4'd0) ? 4'd9 : dn_dig - 4'd1;
        borrow             = (dn_dig == 4'd0);
      end
    end
  end
`endif

  // Per-digit clamp of load data so no digit above 9 can ever be stored.
  always_comb begin
    load_clamped = '0;
    ld_dig       = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      ld_dig                 = load_value[4*k +: 4];
      load_clamped[4*k +: 4] = (ld_dig > 4'd9) ? 4'd9 : ld_dig;
    end
  end

  // Next state: load beats count; at the limit either hold (saturate) or wrap with a pulse.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (load) begin
      q_d = load_clamped;
    end else if (count) begin
      if (!(at_limit && (SATURATE != 0))) begin
`ifdef BCD_DOWN_EN
        q_d = dir_up ? up_val : down_val;
`else
        q_d = up_val;
`endif
        wrap_d = at_limit;
      end
    end
  end

  // Count and wrap registers; clear is asynchronous and overrides everything.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // Terminal count is combinational so a downstream stage can chain on it in the same cycle.
  assign tc   = count & ~load & ~clear & at_limit;
  assign Q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Testbench for bcd_counter_n: wrapping and saturating instances share stimulus and are
// compared against an integer-valued reference model.
module tb_bcd_counter_n;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 16;
  localparam int          MAXV   = 9999;

  logic         clock      = 1'b0;
  logic         clear      = 1'b1;
  logic         count      = 1'b0;
  logic         up         = 1'b1;
  logic         load       = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] q0, q1;
  logic         tc0, tc1, wrap0, wrap1;

  int n_vec = 0;
  int n_err = 0;
  int m_v[2];
  bit m_w[2];

  always #5 clock = ~clock;

  bcd_counter_n #(.DIGITS(DIGITS), .SATURATE(0)) u_wrap (
    .clock(clock), .clear(clear), .count(count), .up(up), .load(load),
    .load_value(load_value), .Q(q0), .tc(tc0), .wrap(wrap0)
  );

  bcd_counter_n #(.DIGITS(DIGITS), .SATURATE(1)) u_sat (
    .clock(clock), .clear(clear), .count(count), .up(up), .load(load),
    .load_value(load_value), .Q(q1), .tc(tc1), .wrap(wrap1)
  );

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < int'(DIGITS); k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_clamped(input logic [W-1:0] b);
    int r, p, d;
    r = 0;
    p = 1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      d = int'(b[4*k +: 4]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
    end
    return r;
  endfunction

  function automatic bit model_dir_up();
`ifdef BCD_DOWN_EN
    return up;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_tc(input int i);
    bit lim;
    lim = model_dir_up() ? (m_v[i] == MAXV) : (m_v[i] == 0);
    return count && !load && !clear && lim;
  endfunction

  // Instance 1 saturates; instance 0 wraps.
  function automatic void model_edge(input int i);
    bit d;
    d = model_dir_up();
    if (clear) begin
      m_v[i] = 0;
      m_w[i] = 1'b0;
    end else if (load) begin
      m_v[i] = from_bcd_clamped(load_value);
      m_w[i] = 1'b0;
    end else if (count) begin
      m_w[i] = 1'b0;
      if (d && m_v[i] == MAXV) begin
        if (i == 0) begin m_v[i] = 0; m_w[i] = 1'b1; end
      end else if (!d && m_v[i] == 0) begin
        if (i == 0) begin m_v[i] = MAXV; m_w[i] = 1'b1; end
      end else begin
        m_v[i] = d ? m_v[i] + 1 : m_v[i] - 1;
      end
    end else begin
      m_w[i] = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic async_clear();
    clear  = 1'b1;
    m_v[0] = 0;
    m_v[1] = 0;
    m_w[0] = 1'b0;
    m_w[1] = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (q0 !== '0 || wrap0 !== 1'b0) begin
      n_err++; $display("FAIL reset_initial got Q=%h wrap=%b want Q=0000 wrap=0", q0, wrap0);
    end
    clear = 1'b0;
    count = 1'b1;
    repeat (3) tick();
    async_clear();
    #1;
    n_vec++;
    if (q0 !== '0 || wrap0 !== 1'b0 || q1 !== '0) begin
      n_err++; $display("FAIL reset_async got Q0=%h wrap0=%b Q1=%h want 0000 0 0000", q0, wrap0, q1);
    end
    clear = 1'b0;
    repeat (12) tick();
    n_vec++;
    if (q0 !== 16'h0012 || q0 !== to_bcd(m_v[0])) begin
      n_err++; $display("FAIL reset_count12 got %h want 0012", q0);
    end
    count = 1'b0;
  endtask

  task automatic test_ripple();
    load = 1'b1; load_value = 16'h0999;
    tick();
    load = 1'b0; count = 1'b1;
    tick();
    n_vec++;
    if (q0 !== 16'h1000 || wrap0 !== 1'b0) begin
      n_err++; $display("FAIL ripple_carry got Q=%h wrap=%b want 1000 0", q0, wrap0);
    end
    load = 1'b1; load_value = 16'h9999;
    tick();
    load = 1'b0;
    #1;
    n_vec++;
    if (tc0 !== 1'b1 || tc1 !== 1'b1) begin
      n_err++; $display("FAIL ripple_tc got tc0=%b tc1=%b want 1 1", tc0, tc1);
    end
    tick();
    n_vec++;
    if (q0 !== 16'h0000 || wrap0 !== 1'b1) begin
      n_err++; $display("FAIL ripple_wrap got Q=%h wrap=%b want 0000 1", q0, wrap0);
    end
    n_vec++;
    if (q1 !== 16'h9999 || wrap1 !== 1'b0) begin
      n_err++; $display("FAIL ripple_sat got Q=%h wrap=%b want 9999 0", q1, wrap1);
    end
    count = 1'b0;
    tick();
    n_vec++;
    if (wrap0 !== 1'b0 || q0 !== to_bcd(m_v[0])) begin
      n_err++; $display("FAIL ripple_wrap_once got wrap=%b Q=%h want 0 %h", wrap0, q0,
                        to_bcd(m_v[0]));
    end
  endtask

  task automatic test_saturate();
    load = 1'b1; load_value = 16'h9998;
    tick();
    load = 1'b0; count = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (tc1 !== exp_tc(1)) begin
        n_err++; $display("FAIL sat_tc step %0d got %b want %b", i, tc1, exp_tc(1));
      end
      tick();
      n_vec++;
      if (wrap1 !== 1'b0 || q1 !== to_bcd(m_v[1])) begin
        n_err++; $display("FAIL sat_step %0d got Q=%h wrap=%b want %h 0", i, q1, wrap1,
                          to_bcd(m_v[1]));
      end
    end
    n_vec++;
    if (q1 !== 16'h9999 || tc1 !== 1'b1) begin
      n_err++; $display("FAIL sat_hold got Q=%h tc=%b want 9999 1", q1, tc1);
    end
    count = 1'b0;
  endtask

  task automatic test_load_clamp();
    load = 1'b1; count = 1'b1; load_value = 16'h3AF5;
    #1;
    n_vec++;
    if (tc0 !== 1'b0) begin
      n_err++; $display("FAIL load_tc got %b want 0", tc0);
    end
    tick();
    n_vec++;
    if (q0 !== 16'h3995 || wrap0 !== 1'b0 || q1 !== 16'h3995) begin
      n_err++; $display("FAIL load_clamp got Q0=%h wrap=%b Q1=%h want 3995 0 3995", q0, wrap0, q1);
    end
    load = 1'b0; count = 1'b0;
  endtask

  task automatic test_down();
    logic [W-1:0] exp_a, exp_b;
    logic         exp_tc_b, exp_wrap_b;
`ifdef BCD_DOWN_EN
    exp_a = 16'h0999; exp_b = 16'h9999; exp_tc_b = 1'b1; exp_wrap_b = 1'b1;
`else
    exp_a = 16'h1001; exp_b = 16'h0001; exp_tc_b = 1'b0; exp_wrap_b = 1'b0;
`endif
    load = 1'b1; load_value = 16'h1000;
    tick();
    load = 1'b0; up = 1'b0; count = 1'b1;
    tick();
    n_vec++;
    if (q0 !== exp_a || q0 !== to_bcd(m_v[0])) begin
      n_err++; $display("FAIL down_borrow got %h want %h", q0, exp_a);
    end
    load = 1'b1; load_value = 16'h0000;
    tick();
    load = 1'b0;
    #1;
    n_vec++;
    if (tc0 !== exp_tc_b) begin
      n_err++; $display("FAIL down_tc got %b want %b", tc0, exp_tc_b);
    end
    tick();
    n_vec++;
    if (q0 !== exp_b || wrap0 !== exp_wrap_b) begin
      n_err++; $display("FAIL down_wrap got Q=%h wrap=%b want %h %b", q0, wrap0, exp_b, exp_wrap_b);
    end
    n_vec++;
    if (q1 !== to_bcd(m_v[1]) || wrap1 !== 1'b0) begin
      n_err++; $display("FAIL down_sat got Q=%h wrap=%b want %h 0", q1, wrap1, to_bcd(m_v[1]));
    end
    up = 1'b1; count = 1'b0;
  endtask

  task automatic test_gating_clear();
    async_clear();
    #1;
    clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      count = (i % 2 == 0);
      tick();
    end
    n_vec++;
    if (q0 !== 16'h0010) begin
      n_err++; $display("FAIL gating got %h want 0010", q0);
    end
    load = 1'b1; count = 1'b1; load_value = 16'h4321;
    async_clear();
    #1;
    n_vec++;
    if (q0 !== '0 || q1 !== '0 || tc0 !== 1'b0) begin
      n_err++; $display("FAIL clear_vs_load got Q0=%h Q1=%h tc=%b want 0000 0000 0", q0, q1, tc0);
    end
    tick();
    n_vec++;
    if (q0 !== '0 || wrap0 !== 1'b0) begin
      n_err++; $display("FAIL clear_hold got Q=%h wrap=%b want 0000 0", q0, wrap0);
    end
    clear = 1'b0; load = 1'b0; count = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      count = ($urandom_range(0, 3) != 0);
      load  = ($urandom_range(0, 11) == 0);
      up    = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       load_value = 16'h9999;
        1:       load_value = 16'h0000;
        2:       load_value = 16'h9997;
        default: load_value = 16'($urandom);
      endcase
      if ($urandom_range(0, 59) == 0) async_clear();
      else clear = 1'b0;
      #1;
      n_vec++;
      if (tc0 !== exp_tc(0) || tc1 !== exp_tc(1)) begin
        n_err++; $display("FAIL rand_tc n=%0d got %b%b want %b%b", n, tc0, tc1, exp_tc(0),
                          exp_tc(1));
      end
      if (clear) begin
        n_vec++;
        if (q0 !== '0 || wrap0 !== 1'b0) begin
          n_err++; $display("FAIL rand_clear n=%0d got Q=%h wrap=%b want 0000 0", n, q0, wrap0);
        end
      end
      tick();
      n_vec++;
      if (q0 !== to_bcd(m_v[0]) || wrap0 !== m_w[0]) begin
        n_err++; $display("FAIL rand_wrap_inst n=%0d got Q=%h wrap=%b want %h %b", n, q0, wrap0,
                          to_bcd(m_v[0]), m_w[0]);
      end
      n_vec++;
      if (q1 !== to_bcd(m_v[1]) || wrap1 !== m_w[1]) begin
        n_err++; $display("FAIL rand_sat_inst n=%0d got Q=%h wrap=%b want %h %b", n, q1, wrap1,
                          to_bcd(m_v[1]), m_w[1]);
      end
    end
    clear = 1'b0; count = 1'b0; load = 1'b0; up = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ripple();
    test_saturate();
    test_load_clamp();
    test_down();
    test_gating_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
